// File: rtl/execute_stage.sv
// Y86-64 Execute stage: ALU, branch/cmov condition, condition-code register
// and the E->M pipeline register, with combinational forwarding outputs.
module execute_stage #(
  parameter int unsigned W      = 64,
  parameter logic [3:0]  RSP_ID = 4'h4,
  parameter logic [3:0]  RNONE  = 4'hF,
  parameter logic [2:0]  CC_RST = 3'b100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   e_stat,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [3:0]   e_rA,
  input  logic [3:0]   e_rB,
  input  logic [W-1:0] e_valC,
  input  logic [W-1:0] e_valP,
  input  logic [W-1:0] e_valA,
  input  logic [W-1:0] e_valB,
  input  logic         cc_hold,
  input  logic         m_bubble,
  output logic [W-1:0] fwd_valE,
  output logic [3:0]   fwd_dstE,
  output logic         e_cnd,
  output logic [2:0]   m_stat,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic [2:0]   cc_out
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fun;
  logic [W-1:0] alu_out;
  logic         zf_next;
  logic         sf_next;
  logic         of_next;
  logic [2:0]   cc;
  logic         cc_we;
  logic         cnd_raw;
  logic [3:0]   dst_e;
  logic [3:0]   dst_m;
  logic [W-1:0] val_a_sel;

  wire zf = cc[2];
  wire sf = cc[1];
  wire of = cc[0];

  // Operand selection
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_a = '0;
    unique case (e_icode)
      I_RRMOVQ, I_OPQ:             alu_a = e_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valC;
      I_CALL, I_PUSHQ:             alu_a = ~W'(7);   // -8
      I_RET, I_POPQ:               alu_a = W'(8);
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (e_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  assign alu_fun = (e_icode == I_OPQ) ? e_ifun : ALU_ADD;

  always_comb begin
    alu_out = '0;
    of_next = 1'b0;
    unique case (alu_fun)
      ALU_ADD: begin
        alu_out = alu_b + alu_a;
        of_next = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_b[W-1]);
      end
      ALU_SUB: begin
        alu_out = alu_b - alu_a;
        of_next = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_b[W-1]);
      end
      ALU_AND: alu_out = alu_b & alu_a;
      ALU_XOR: alu_out = alu_b ^ alu_a;
      default: begin
        alu_out = '0;
        of_next = 1'b0;
      end
    endcase
  end

  assign zf_next = (alu_out == '0);
  assign sf_next = alu_out[W-1];

  // Condition is judged against the flags already committed, not this result.
  always_comb begin
    cnd_raw = 1'b0;
    unique case (e_ifun)
      C_ALWAYS: cnd_raw = 1'b1;
      C_LE:     cnd_raw = (sf ^ of) | zf;
      C_L:      cnd_raw = sf ^ of;
      C_E:      cnd_raw = zf;
      C_NE:     cnd_raw = ~zf;
      C_GE:     cnd_raw = ~(sf ^ of);
      C_G:      cnd_raw = ~(sf ^ of) & ~zf;
      default:  cnd_raw = 1'b0;
    endcase
  end

  assign e_cnd = ((e_icode == I_RRMOVQ) || (e_icode == I_JXX)) ? cnd_raw : 1'b0;

  always_comb begin
    dst_e = RNONE;
    unique case (e_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:      dst_e = e_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = RSP_ID;
      default:                        dst_e = RNONE;
    endcase
    // A failed cmov writes nothing.
    if ((e_icode == I_RRMOVQ) && !e_cnd) dst_e = RNONE;
  end

  assign dst_m     = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) ? e_rA : RNONE;
  assign val_a_sel = (e_icode == I_CALL) ? e_valP : e_valA;

  assign fwd_valE = alu_out;
  assign fwd_dstE = dst_e;

  // Flags only move for an AOK OPq that is actually advancing into M.
  assign cc_we = (e_icode == I_OPQ) && (e_stat == STAT_AOK) && !cc_hold && !m_bubble;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RST;
    end else if (cc_we) begin
      cc <= {zf_next, sf_next, of_next};
    end
  end

  assign cc_out = cc;

  // A bubble loads exactly the reset image, so M sees an AOK nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stat  <= STAT_AOK;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else if (m_bubble) begin
      m_stat  <= STAT_AOK;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else begin
      m_stat  <= e_stat;
      m_icode <= e_icode;
      m_cnd   <= e_cnd;
      m_valE  <= alu_out;
      m_valA  <= val_a_sel;
      m_dstE  <= dst_e;
      m_dstM  <= dst_m;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; expected values are
// hand-computed Y86-64 results.
module tb_execute_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   e_stat;
  logic [3:0]   e_icode, e_ifun, e_rA, e_rB;
  logic [W-1:0] e_valC, e_valP, e_valA, e_valB;
  logic         cc_hold, m_bubble;
  logic [W-1:0] fwd_valE;
  logic [3:0]   fwd_dstE;
  logic         e_cnd;
  logic [2:0]   m_stat;
  logic [3:0]   m_icode;
  logic         m_cnd;
  logic [W-1:0] m_valE, m_valA;
  logic [3:0]   m_dstE, m_dstM;
  logic [2:0]   cc_out;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_rA(e_rA), .e_rB(e_rB),
    .e_valC(e_valC), .e_valP(e_valP), .e_valA(e_valA), .e_valB(e_valB),
    .cc_hold(cc_hold), .m_bubble(m_bubble),
    .fwd_valE(fwd_valE), .fwd_dstE(fwd_dstE), .e_cnd(e_cnd),
    .m_stat(m_stat), .m_icode(m_icode), .m_cnd(m_cnd),
    .m_valE(m_valE), .m_valA(m_valA), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc,
                       input logic [63:0] vala, input logic [63:0] valb, input logic [63:0] valp);
    e_stat = stat; e_icode = icode; e_ifun = ifun; e_rA = ra; e_rB = rb;
    e_valC = valc; e_valA = vala; e_valB = valb; e_valP = valp;
  endtask

  // Advance through one active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; cc_hold = 1'b0; m_bubble = 1'b0;
    drive(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h0);
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_stat",  64'(m_stat),  64'd1);
    check("rst_icode", 64'(m_icode), 64'h1);
    check("rst_cnd",   64'(m_cnd),   64'd0);
    check("rst_valE",  m_valE,       64'h0);
    check("rst_valA",  m_valA,       64'h0);
    check("rst_dstE",  64'(m_dstE),  64'hF);
    check("rst_dstM",  64'(m_dstM),  64'hF);
    check("rst_cc",    64'(cc_out),  64'b100);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("nop_icode", 64'(m_icode), 64'h1);
    check("nop_dstE",  64'(m_dstE),  64'hF);
    check("nop_cc",    64'(cc_out),  64'b100);

    // OPq sub: 3 - 5
    @(negedge clk) drive(3'd1, 4'h6, 4'h1, 4'hF, 4'h2, 64'h0, 64'd5, 64'd3, 64'h0);
    #1;
    check("sub_fwd_valE", fwd_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_fwd_dstE", 64'(fwd_dstE), 64'h2);
    check("sub_cnd_opq",  64'(e_cnd), 64'd0);
    tick();
    check("sub_m_valE",  m_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_m_dstE",  64'(m_dstE), 64'h2);
    check("sub_m_icode", 64'(m_icode), 64'h6);
    check("sub_cc",      64'(cc_out), 64'b010);

    // Signed add overflow
    @(negedge clk) drive(3'd1, 4'h6, 4'h0, 4'hF, 4'h3, 64'h0,
                         64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0);
    #1 check("add_fwd_valE", fwd_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("add_cc", 64'(cc_out), 64'b011);

    // cc_hold: 5-5 would set ZF, but flags must stay
    @(negedge clk) begin
      cc_hold = 1'b1;
      drive(3'd1, 4'h6, 4'h1, 4'hF, 4'h3, 64'h0, 64'd5, 64'd5, 64'h0);
    end
    tick();
    check("hold_m_valE", m_valE, 64'h0);
    check("hold_cc",     64'(cc_out), 64'b011);
    @(negedge clk) cc_hold = 1'b0;

    // cmove with ZF=0 cancels
    drive(3'd1, 4'h2, 4'h3, 4'h1, 4'h5, 64'h0, 64'hABCD, 64'h0, 64'h0);
    #1;
    check("cmov0_cnd",      64'(e_cnd), 64'd0);
    check("cmov0_fwd_dstE", 64'(fwd_dstE), 64'hF);
    tick();
    check("cmov0_m_dstE", 64'(m_dstE), 64'hF);
    check("cmov0_m_valE", m_valE, 64'hABCD);
    check("cmov0_m_cnd",  64'(m_cnd), 64'd0);

    // Jump conditions on CC=011 (ZF=0, SF=1, OF=1); non-branch forced 0
    @(negedge clk) drive(3'd1, 4'h7, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h0);
    #1 check("jl_cnd", 64'(e_cnd), 64'd0);
    e_ifun = 4'h4;
    #1 check("jne_cnd", 64'(e_cnd), 64'd1);
    e_ifun = 4'h6;
    #1 check("jg_cnd", 64'(e_cnd), 64'd1);
    e_icode = 4'h0; e_ifun = 4'h0;
    #1 check("halt_cnd", 64'(e_cnd), 64'd0);

    // xor to zero -> CC=100
    @(negedge clk) drive(3'd1, 4'h6, 4'h3, 4'hF, 4'h1, 64'h0, 64'h55, 64'h55, 64'h0);
    tick();
    check("xor_cc", 64'(cc_out), 64'b100);

    // cmove with ZF=1 moves
    @(negedge clk) drive(3'd1, 4'h2, 4'h3, 4'h1, 4'h5, 64'h0, 64'h1234, 64'h0, 64'h0);
    #1;
    check("cmov1_cnd",      64'(e_cnd), 64'd1);
    check("cmov1_fwd_dstE", 64'(fwd_dstE), 64'h5);
    tick();
    check("cmov1_m_dstE", 64'(m_dstE), 64'h5);
    check("cmov1_m_valE", m_valE, 64'h1234);
    check("cmov1_m_cnd",  64'(m_cnd), 64'd1);

    // call
    @(negedge clk) drive(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0, 64'h999, 64'h100, 64'h40);
    tick();
    check("call_m_valE", m_valE, 64'hF8);
    check("call_m_valA", m_valA, 64'h40);
    check("call_m_dstE", 64'(m_dstE), 64'h4);
    check("call_m_dstM", 64'(m_dstM), 64'hF);
    check("call_cc",     64'(cc_out), 64'b100);

    // popq %rbx
    @(negedge clk) drive(3'd1, 4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h777, 64'h100, 64'h0);
    tick();
    check("pop_m_valE", m_valE, 64'h108);
    check("pop_m_valA", m_valA, 64'h777);
    check("pop_m_dstE", 64'(m_dstE), 64'h4);
    check("pop_m_dstM", 64'(m_dstM), 64'h3);

    // mrmovq 0x20(%rdx), %rdi
    @(negedge clk) drive(3'd1, 4'h5, 4'h0, 4'h7, 4'h2, 64'h20, 64'h0, 64'h100, 64'h0);
    tick();
    check("mr_m_valE", m_valE, 64'h120);
    check("mr_m_dstE", 64'(m_dstE), 64'hF);
    check("mr_m_dstM", 64'(m_dstM), 64'h7);

    // Bubble over an OPq: 1+1 would clear ZF
    @(negedge clk) begin
      m_bubble = 1'b1;
      drive(3'd1, 4'h6, 4'h0, 4'hF, 4'h2, 64'h0, 64'd1, 64'd1, 64'h0);
    end
    #1 check("bub_fwd_valE", fwd_valE, 64'd2);
    tick();
    check("bub_m_icode", 64'(m_icode), 64'h1);
    check("bub_m_stat",  64'(m_stat), 64'd1);
    check("bub_m_valE",  m_valE, 64'h0);
    check("bub_m_dstE",  64'(m_dstE), 64'hF);
    check("bub_m_dstM",  64'(m_dstM), 64'hF);
    check("bub_cc",      64'(cc_out), 64'b100);
    @(negedge clk) m_bubble = 1'b0;
    tick();
    check("b2b_m_icode", 64'(m_icode), 64'h6);
    check("b2b_m_valE",  m_valE, 64'd2);
    check("b2b_cc",      64'(cc_out), 64'b000);

    // Non-AOK OPq: stat propagates, flags frozen, dstE still computed
    @(negedge clk) drive(3'd2, 4'h6, 4'h1, 4'hF, 4'h2, 64'h0, 64'd1, 64'd0, 64'h0);
    tick();
    check("hlt_m_stat",  64'(m_stat), 64'd2);
    check("hlt_m_icode", 64'(m_icode), 64'h6);
    check("hlt_m_dstE",  64'(m_dstE), 64'h2);
    check("hlt_cc",      64'(cc_out), 64'b000);

    // Reset across an in-flight OPq discards it
    @(negedge clk) begin
      drive(3'd1, 4'h6, 4'h1, 4'hF, 4'h2, 64'h0, 64'd1, 64'd0, 64'h0);
      rst_n = 1'b0;
    end
    tick();
    check("mid_rst_icode", 64'(m_icode), 64'h1);
    check("mid_rst_cc",    64'(cc_out), 64'b100);
    @(negedge clk) begin
      rst_n = 1'b1;
      drive(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h0);
    end
    tick();
    check("post_rst_icode", 64'(m_icode), 64'h1);
    check("post_rst_dstE",  64'(m_dstE), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline Execute stage; sits directly downstream of the D→E pipeline register.
- Consumes the E-stage fields, computes the ALU result and branch/cmov condition, and owns the condition-code register (ZF/SF/OF).
- Registers results into the E→M pipeline register, with bubble insertion.
- Exposes combinational valE/dstE for the forwarding network.

Parameters:
- W, 64, datapath width of valC/valA/valB/valE.
- RSP_ID, 4'h4, register ID of %rsp.
- RNONE, 4'hF, "no register" ID.
- CC_RST, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- e_stat  in  3  E-stage status (1=AOK, 2=HLT, 3=ADR, 4=INS).
- e_icode  in  4  E-stage instruction code.
- e_ifun  in  4  E-stage function code.
- e_rA  in  4  rA field.
- e_rB  in  4  rB field.
- e_valC  in  W  constant word.
- e_valP  in  W  incremented PC (unused except passthrough to m_valA for call).
- e_valA  in  W  forwarded operand A.
- e_valB  in  W  forwarded operand B.
- cc_hold  in  1  1 = inhibit CC update this cycle (exception in M/W, from hazard unit).
- m_bubble  in  1  1 = load a bubble into the M register this cycle.
- fwd_valE  out  W  combinational ALU result.
- fwd_dstE  out  4  combinational effective dstE (after cmov cancel).
- e_cnd  out  1  combinational condition result.
- m_stat  out  3  registered M-stage status.
- m_icode  out  4  registered M-stage icode.
- m_cnd  out  1  registered cnd.
- m_valE  out  W  registered ALU result.
- m_valA  out  W  registered store/return data.
- m_dstE  out  4  registered dstE.
- m_dstM  out  4  registered dstM.
- cc_out  out  3  current {ZF,SF,OF}.

Behaviour:
- Reset (rst_n=0, asynchronous, holds while low): m_stat=1, m_icode=1 (nop), m_cnd=0, m_valE=0, m_valA=0, m_dstE=RNONE, m_dstM=RNONE, CC=CC_RST.
- aluA select:
  - icode 2 or 6 → valA
  - icode 3, 4, 5 → valC
  - icode 8 or A → −8
  - icode 9 or B → +8
  - else 0
- aluB select:
  - icode 4, 5, 6, 8, 9, A, B → valB
  - icode 2, 3 → 0
  - else 0
- ALU function: ifun when icode=6, otherwise add.
  - 0 = B+A, 1 = B−A, 2 = B&A, 3 = B^A; ifun>3 on OPq yields 0.
  - Arithmetic is modulo 2^W, no carry-out.
- Flags from the OPq result:
  - ZF = (valE==0).
  - SF = valE[W−1].
  - OF, add: sign(A)==sign(B) and sign(valE)≠sign(B).
  - OF, sub: sign(A)≠sign(B) and sign(valE)≠sign(B).
  - OF, and/xor: 0.
- CC update at posedge only when icode=6, e_stat=1, cc_hold=0 and m_bubble=0. Otherwise CC holds.
- e_cnd evaluates on current CC (not the result being written):
  - ifun 0: 1
  - ifun 1: (SF^OF)|ZF
  - ifun 2: SF^OF
  - ifun 3: ZF
  - ifun 4: ~ZF
  - ifun 5: ~(SF^OF)
  - ifun 6: ~(SF^OF)&~ZF
  - else 0
  - Meaningful for icode 2/7; forced 0 for other icodes.
- dstE:
  - icode 2, 3, 6 → rB
  - icode 8, 9, A, B → RSP_ID
  - else RNONE
  - icode=2 with e_cnd=0 → RNONE (cmov cancel).
- dstM: icode 5 or B → rA; else RNONE.
- m_valA source: valP when icode=8, else valA.
- Latency 1: M register loads all next values each posedge.
- m_bubble=1 loads the reset values (except CC) and overrides everything.
- Non-AOK e_stat:
  - Stat and icode propagate normally.
  - No CC update.
  - dstE and dstM are still computed; squashing is the hazard unit's job.
- Reset asserted mid-instruction discards the in-flight result; first post-reset cycle shows a nop in M.

Test Plan:
1. Reset: rst_n low mid-cycle → immediately m_icode=1, m_dstE=F, m_dstM=F, cc_out=3'b100; release, hold a nop at the E inputs → values unchanged.
2. OPq sub: icode=6, ifun=1, valA=5, valB=3, rB=2 → fwd_valE=0xFFFF_FFFF_FFFF_FFFE; next cycle m_valE=that, m_dstE=2, cc_out=3'b010.
3. Add overflow: valA=valB=0x7FFF_FFFF_FFFF_FFFF, ifun=0 → valE=0xFFFF_FFFF_FFFF_FFFE, cc_out=3'b011; repeat with cc_hold=1 → CC unchanged.
4. Cmov: CC=ZF=0, icode=2, ifun=3 (cmove), rB=5 → e_cnd=0, fwd_dstE=F, m_dstE=F; CC=3'b100 → m_dstE=5, m_valE=valA.
5. Stack ops: call with valB=0x100, valP=0x40 → m_valE=0xF8, m_valA=0x40, m_dstE=4; popq rA=3 with valB=0x100 → m_valE=0x108, m_dstE=4, m_dstM=3.
6. Bubble: OPq in E with m_bubble=1 → M shows nop/AOK/F/F, CC unchanged; a back-to-back OPq with m_bubble=0 updates CC normally.
